// File: rtl/mmio_io_bridge.sv
// Memory-mapped switch/LED peripheral: debounced switches with sticky rising-edge flags and irq,
// a CPU LED register, and a fixed or auto-scanning view of the debug channels.
module mmio_io_bridge #(
  parameter int              DATA_W       = 16,
  parameter int              ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] IO_BASE    = 16'hFF00,
  parameter int              SW_W         = 4,
  parameter int              LED_W        = 8,
  parameter int              NCH          = 4,
  parameter int              DEBOUNCE_CYC = 16,
  parameter int              SCAN_CYC     = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   we,
  output logic [DATA_W-1:0]      rdata,
  output logic                   hit,
  input  logic [SW_W-1:0]        sw_raw,
  input  logic [NCH*LED_W-1:0]   dbg,
  output logic [LED_W-1:0]       led,
  output logic                   sw_irq
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int SC_W  = $clog2(SCAN_CYC);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [ADDR_W-1:0] off;
  logic              wr_led, wr_edge, wr_ctrl;

  logic [LED_W-1:0]  led_data_reg;
  logic [SW_W-1:0]   sync1_reg, sync2_reg;
  logic [SW_W-1:0]   sw_state_reg;
  logic [SW_W-1:0]   sw_edge_reg, sw_edge_next;
  logic [SW_W-1:0]   accept;
  logic [SW_W-1:0]   edge_clr;
  logic              irq_en_reg;
  logic [1:0]        mode_reg;
  logic [3:0]        chan_reg;
  logic [SC_W-1:0]   scan_cnt_reg, scan_cnt_next;
  logic [IDX_W-1:0]  scan_idx_reg, scan_idx_next;
  logic [LED_W-1:0]  led_reg, led_next;
  logic              sw_irq_reg;
  logic [DATA_W-1:0] rdata_mux;
  logic [LED_W-1:0]  ch [NCH];
  logic              unused_wdata;

  // Unsigned offset compare covers both ends of the window in one test.
  assign off     = addr - IO_BASE;
  assign hit     = (off < ADDR_W'(4));
  assign wr_led  = we & hit & (off[1:0] == 2'd0);
  assign wr_edge = we & hit & (off[1:0] == 2'd2);
  assign wr_ctrl = we & hit & (off[1:0] == 2'd3);

  assign unused_wdata = ^wdata;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch[gi] = dbg[gi*LED_W +: LED_W];
    end

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_deb
      logic [DB_W-1:0] cnt_reg;
      logic            mism;

      assign mism       = sync2_reg[gi] ^ sw_state_reg[gi];
      assign accept[gi] = mism & (cnt_reg == DB_W'(DEBOUNCE_CYC - 1));

      // Counts only while the synced bit disagrees with the accepted state.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (!mism || accept[gi]) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end
    end
  endgenerate

  // A rising edge landing on the same cycle as a write-1-clear keeps the flag set.
  always_comb begin
    edge_clr     = wr_edge ? wdata[SW_W-1:0] : '0;
    sw_edge_next = (sw_edge_reg & ~edge_clr) | (accept & sync2_reg);
  end

  always_comb begin
    scan_cnt_next = '0;
    scan_idx_next = '0;
    if (mode_reg == 2'b10) begin
      if (scan_cnt_reg == SC_W'(SCAN_CYC - 1)) begin
        scan_idx_next = (scan_idx_reg == IDX_W'(NCH - 1)) ? '0 : scan_idx_reg + IDX_W'(1);
      end else begin
        scan_cnt_next = scan_cnt_reg + SC_W'(1);
        scan_idx_next = scan_idx_reg;
      end
    end
  end

  always_comb begin
    led_next = led_data_reg;
    case (mode_reg)
      2'b01: begin
        led_next = '0;
        for (int k = 0; k < NCH; k++) begin
          if (chan_reg == 4'(k)) led_next = ch[k];
        end
      end
      2'b10: begin
        led_next = '0;
        for (int k = 0; k < NCH; k++) begin
          if (scan_idx_reg == IDX_W'(k)) led_next = ch[k];
        end
      end
      default: led_next = led_data_reg;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    if (hit) begin
      case (off[1:0])
        2'd0: rdata_mux[LED_W-1:0] = led_data_reg;
        2'd1: rdata_mux[SW_W-1:0]  = sw_state_reg;
        2'd2: rdata_mux[SW_W-1:0]  = sw_edge_reg;
        default: begin
          rdata_mux[0]   = irq_en_reg;
          rdata_mux[2:1] = mode_reg;
          rdata_mux[7:4] = chan_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_data_reg <= '0;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      sw_state_reg <= '0;
      sw_edge_reg  <= '0;
      irq_en_reg   <= 1'b0;
      mode_reg     <= 2'b00;
      chan_reg     <= 4'd0;
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
      led_reg      <= '0;
      sw_irq_reg   <= 1'b0;
    end else begin
      sync1_reg    <= sw_raw;
      sync2_reg    <= sync1_reg;
      sw_state_reg <= sw_state_reg ^ accept;
      sw_edge_reg  <= sw_edge_next;
      if (wr_led) begin
        led_data_reg <= wdata[LED_W-1:0];
      end
      if (wr_ctrl) begin
        irq_en_reg <= wdata[0];
        mode_reg   <= wdata[2:1];
        chan_reg   <= wdata[7:4];
      end
      scan_cnt_reg <= scan_cnt_next;
      scan_idx_reg <= scan_idx_next;
      led_reg      <= led_next;
      sw_irq_reg   <= irq_en_reg & (|sw_edge_reg);
    end
  end

  assign rdata  = rdata_mux;
  assign led    = led_reg;
  assign sw_irq = sw_irq_reg;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed bench for mmio_io_bridge with short debounce and scan periods.
module tb_mmio_io_bridge;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;
  logic        hit;
  logic [3:0]  sw_raw;
  logic [31:0] dbg;
  logic [7:0]  led;
  logic        sw_irq;

  int n_cmp = 0;
  int n_err = 0;

  mmio_io_bridge #(
    .DEBOUNCE_CYC(4),
    .SCAN_CYC(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .we(we),
    .rdata(rdata),
    .hit(hit),
    .sw_raw(sw_raw),
    .dbg(dbg),
    .led(led),
    .sw_irq(sw_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [1:0] o, input logic [15:0] d);
    addr  = 16'hFF00 + 16'(o);
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [1:0] o, input logic [15:0] exp);
    addr = 16'hFF00 + 16'(o);
    we   = 1'b0;
    #1;
    chk(tag, 32'(rdata), 32'(exp));
  endtask

  initial begin
    reset  = 1'b1;
    addr   = 16'h0000;
    wdata  = 16'h0000;
    we     = 1'b0;
    sw_raw = 4'b0000;
    dbg    = {8'h44, 8'h33, 8'h22, 8'h11};
    step(2);
    reset = 1'b0;
    step(1);

    // Reset state and decode window
    rd("rst_led_data", 2'd0, 16'h0000);
    rd("rst_sw_state", 2'd1, 16'h0000);
    rd("rst_sw_edge", 2'd2, 16'h0000);
    rd("rst_ctrl", 2'd3, 16'h0000);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_irq", 32'(sw_irq), 32'h0);
    addr = 16'hFF03; #1;
    chk("hit_ff03", 32'(hit), 32'h1);
    addr = 16'hFF04; #1;
    chk("hit_ff04", 32'(hit), 32'h0);
    chk("rdata_ff04", 32'(rdata), 32'h0000);
    addr = 16'hFEFF; #1;
    chk("hit_feff", 32'(hit), 32'h0);
    step(1);

    // LED register, mode 00
    wr(2'd0, 16'h00A5);
    chk("led_pre", 32'(led), 32'h00);
    step(1);
    chk("led_a5", 32'(led), 32'hA5);
    rd("rd_led_data", 2'd0, 16'h00A5);
    step(1);

    // Debounce: held input accepted after 6 cycles
    sw_raw = 4'b0001;
    step(5);
    rd("sw_before_6", 2'd1, 16'h0000);
    step(1);
    rd("sw_after_6", 2'd1, 16'h0001);
    rd("edge_after_6", 2'd2, 16'h0001);

    // 3-cycle glitch on bit1 is rejected
    step(1);
    sw_raw = 4'b0011;
    step(3);
    sw_raw = 4'b0001;
    step(10);
    rd("glitch_state", 2'd1, 16'h0001);
    rd("glitch_edge", 2'd2, 16'h0001);

    // Interrupt enable and write-1-clear
    step(1);
    wr(2'd3, 16'h0001);
    chk("irq_lag", 32'(sw_irq), 32'h0);
    step(1);
    chk("irq_set", 32'(sw_irq), 32'h1);
    rd("rd_ctrl", 2'd3, 16'h0001);
    step(1);
    wr(2'd2, 16'h0001);
    rd("edge_clr", 2'd2, 16'h0000);
    step(1);
    chk("irq_clr", 32'(sw_irq), 32'h0);

    // New edge on bit2 coincides with a clear of bit2: set wins
    sw_raw = 4'b0101;
    step(5);
    rd("sw_pre_race", 2'd1, 16'h0001);
    wr(2'd2, 16'h0004);
    rd("race_state", 2'd1, 16'h0005);
    rd("race_edge", 2'd2, 16'h0004);
    step(1);
    chk("race_irq", 32'(sw_irq), 32'h1);

    // Falling edge sets nothing; ro register ignores writes
    wr(2'd2, 16'h000F);
    sw_raw = 4'b0100;
    step(7);
    rd("fall_state", 2'd1, 16'h0004);
    rd("fall_edge", 2'd2, 16'h0000);
    step(1);
    wr(2'd1, 16'h000F);
    rd("ro_ignored", 2'd1, 16'h0004);
    step(1);

    // Auto-scan: 8-cycle dwell per channel, wrap to channel 0
    wr(2'd3, 16'h0004);
    step(1);
    chk("scan_ch0", 32'(led), 32'h11);
    step(8);
    chk("scan_ch1", 32'(led), 32'h22);
    step(8);
    chk("scan_ch2", 32'(led), 32'h33);
    step(8);
    chk("scan_ch3", 32'(led), 32'h44);
    step(8);
    chk("scan_wrap", 32'(led), 32'h11);

    // Fixed channel select and reserved mode
    wr(2'd3, 16'h0022);
    step(1);
    chk("chan2", 32'(led), 32'h33);
    wr(2'd3, 16'h0032);
    step(1);
    chk("chan3", 32'(led), 32'h44);
    wr(2'd3, 16'h0052);
    step(1);
    chk("chan5_zero", 32'(led), 32'h00);
    wr(2'd3, 16'h0006);
    step(1);
    chk("mode11", 32'(led), 32'hA5);

    // Reset mid-scan and mid-debounce acts without a clock edge
    wr(2'd3, 16'h0004);
    step(9);
    chk("prerst_led", 32'(led), 32'h22);
    sw_raw = 4'b1100;
    step(3);
    reset = 1'b1;
    #2;
    chk("arst_led", 32'(led), 32'h00);
    chk("arst_idx", 32'(dut.scan_idx_reg), 32'h0);
    chk("arst_irq", 32'(sw_irq), 32'h0);
    rd("arst_state", 2'd1, 16'h0000);
    rd("arst_ctrl", 2'd3, 16'h0000);
    step(1);
    reset = 1'b0;
    step(6);
    rd("post_state", 2'd1, 16'h000C);
    rd("post_edge", 2'd2, 16'h000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
